ysyx_22041207_dcache_ctrl: RTL

//  Load/store controller sitting between the LSU and the 2-way data cache.

---
 rtl/ysyx_22041207_dcache_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ysyx_22041207_dcache_ctrl.sv
// Load/store controller between the LSU and the 2-way data cache: load hits served from cache,
// cacheable load misses refilled, stores written through; MMIO bypasses the cache.
module ysyx_22041207_dcache_ctrl #(
  parameter logic [63:0] CACHE_BASE  = 64'h8000_0000,
  parameter logic [63:0] CACHE_LIMIT = 64'h8800_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic [63:0] cache_raddr,
  input  logic        cache_hit,
  input  logic [63:0] cache_rdata,
  output logic        cache_upd,
  output logic [63:0] cache_upd_addr,
  output logic [63:0] cache_upd_data,
  output logic        cache_wupd,
  output logic [63:0] cache_wdata,
  output logic [7:0]  cache_wmask,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [2:0] {StIdle, StLookup, StMemReq, StMemWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        wen_q;
  logic [63:0] addr_q, wdata_q;
  logic [7:0]  wmask_q;
  logic        hit_q, hit_d;
  logic [63:0] rdata_q, rdata_d;
  logic        latch;
  logic        cacheable;

  assign cacheable = (addr_q >= CACHE_BASE) && (addr_q < CACHE_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      hit_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      rdata_q <= rdata_d;
      if (latch) begin
        wen_q   <= req_wen;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    rdata_d = rdata_q;
    latch   = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          latch   = 1'b1;
          state_d = StLookup;
        end
      end
      StLookup: begin
        // hit_q also set on the load-hit path, so a refill in RESP implies a miss
        hit_d = cacheable & cache_hit;
        if (!wen_q && cacheable && cache_hit) begin
          rdata_d = cache_rdata;
          state_d = StResp;
        end else begin
          state_d = StMemReq;
        end
      end
      StMemReq: begin
        if (mem_req_ready) state_d = StMemWait;
      end
      StMemWait: begin
        if (mem_resp_valid) begin
          if (!wen_q) rdata_d = mem_rdata;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign req_ready      = (state_q == StIdle);
  assign resp_valid     = (state_q == StResp);
  assign resp_rdata     = rdata_q;
  assign cache_raddr    = addr_q;
  assign cache_upd      = resp_valid && !wen_q && cacheable && !hit_q;
  assign cache_upd_addr = {addr_q[63:3], 3'b000};
  assign cache_upd_data = rdata_q;
  assign cache_wupd     = resp_valid && wen_q && hit_q;
  assign cache_wdata    = wdata_q;
  assign cache_wmask    = wmask_q;
  assign mem_req_valid  = (state_q == StMemReq);
  assign mem_we         = wen_q;
  assign mem_addr       = {addr_q[63:3], 3'b000};
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;

endmodule
